// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Opcode fields and the queue-entry bundle passed between fetch and decode.
package instr_fetch_queue_pkg;

  localparam logic [31:0] NOP     = 32'hF000_0000;
  localparam logic [7:0]  R_RET   = 8'd253;
  localparam logic [7:0]  MOVL_OP = 8'h1C;
  localparam logic [7:0]  RET_OP  = 8'hD0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
  } ifq_entry_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sext11(
    input logic [10:0] v
  );
    return {{21{v[10]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Decode-side valid/ready bundle of the fetch queue.
// master drives the head entry, slave returns ready.
interface instr_fetch_queue_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_taken;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_taken,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_taken,
    output out_ready
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// ifq_fifo: circular queue holding fetched entries.
// Push while full is legal when a pop happens in the same cycle.
module ifq_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [64:0]
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  rp;
  logic [AW-1:0]  wp;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rp];
  assign valid = (count != '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage with a decoupling queue toward decode.
// Optional return-address stack enabled by defining IFQ_RAS_EN.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          PC_W      = 15,
  parameter int          DEPTH     = 4,
  parameter int          RAS_DEPTH = 8,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [31:0]                  instr_addr,
  input  logic [31:0]                  instr_rdata,
  output logic [PC_W-1:0]              pred_pc,
  output logic                         pred_en,
  input  logic                         pred_taken,
  input  logic                         redirect_en,
  input  logic [31:0]                  redirect_pc,
  instr_fetch_queue_if.master          fetch_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (RAS_DEPTH < 1 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
    $error("RAS_DEPTH must be a power of two");
  end

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] ras_top;
  logic            resp_valid;
  logic            fetch_go;
  logic            is_jump;
  logic            is_branch;
  logic            is_ret;
  logic            link;
  logic            ras_hit;
  logic            push;
  logic            deq;
  logic            q_valid;
  logic [31:0]     instr;
  logic [31:0]     joff;
  logic [31:0]     boff;
  ifq_entry_t      entry;
  ifq_entry_t      head;
  logic            unused_hi;

  assign instr     = instr_rdata;
  assign unused_hi = ^redirect_pc;

  assign is_jump   = instr[31] & instr[30] & instr[29] & instr[27];
  assign is_branch = instr[31] & ~instr[30];
  assign is_ret    = (instr[31:24] == RET_OP);
  assign link      = instr[24];

  assign joff    = sext16(instr[23:8]);
  assign boff    = sext11(instr[26:16]);
  assign pc_inc  = pc + 1'b1;
  assign jmp_tgt = pc + joff[PC_W-1:0];
  assign br_tgt  = pc + boff[PC_W-1:0];

  assign deq      = fetch_out.out_valid & fetch_out.out_ready;
  assign fetch_go = resp_valid & ~redirect_en
                  & ((occupancy != FULL) | deq);

  assign pred_pc = pc;
  assign pred_en = resp_valid & is_branch;

  always_comb begin
    next_pc = pc_inc;
    if (reset) begin
      next_pc = RESET_PC[PC_W-1:0];
    end else if (redirect_en) begin
      next_pc = redirect_pc[PC_W-1:0];
    end else if (!fetch_go) begin
      next_pc = pc;
    end else if (is_jump) begin
      next_pc = jmp_tgt;
    end else if (ras_hit) begin
      next_pc = ras_top;
    end else if (is_branch && pred_taken) begin
      next_pc = br_tgt;
    end
  end

  assign instr_addr = 32'(next_pc);

  always_ff @(posedge clock) begin
    pc <= next_pc;
    if (reset) begin
      resp_valid <= 1'b1;
    end else begin
      resp_valid <= 1'b1;
    end
  end

  // A link jump turns into a move of the return address into R_RET.
  always_comb begin
    entry.pc    = 32'(pc);
    entry.instr = instr;
    entry.taken = is_jump | ras_hit | (is_branch & pred_taken);
    if (is_jump) begin
      entry.instr = {MOVL_OP, 16'(pc_inc), R_RET};
    end
  end

  assign push = fetch_go & ~(is_jump & ~link);

`ifdef IFQ_RAS_EN
  localparam int RW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RW:0] RAS_FULL = (RW + 1)'(RAS_DEPTH);

  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [RW-1:0]   ras_wp;
  logic [RW:0]     ras_cnt;

  assign ras_top = ras[ras_wp - 1'b1];
  assign ras_hit = is_ret & (ras_cnt != '0);

  // Pushing onto a full stack silently overwrites the oldest slot.
  always_ff @(posedge clock) begin
    if (reset || redirect_en) begin
      ras_wp  <= '0;
      ras_cnt <= '0;
    end else if (fetch_go && is_jump && link) begin
      ras[ras_wp] <= pc_inc;
      ras_wp      <= ras_wp + 1'b1;
      if (ras_cnt != RAS_FULL) begin
        ras_cnt <= ras_cnt + 1'b1;
      end
    end else if (fetch_go && ras_hit) begin
      ras_wp  <= ras_wp - 1'b1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end
`else
  assign ras_top = '0;
  assign ras_hit = 1'b0;
`endif

  ifq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (ifq_entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_en),
    .push      (push),
    .push_data (entry),
    .pop       (deq),
    .head      (head),
    .valid     (q_valid),
    .count     (occupancy)
  );

  assign fetch_out.out_valid = q_valid;
  assign fetch_out.out_instr = q_valid ? head.instr : NOP;
  assign fetch_out.out_pc    = head.pc;
  assign fetch_out.out_taken = q_valid & head.taken;

endmodule
